vx_mem_adapter: RTL

Parametrised memory-interface width adapter for narrowing a wide source port onto a narrower or equal-width destination memory port. Each source request is split into P = SRC_DATA_WIDTH/DST_DATA_WIDTH destination beats. Empty write beats can optionally be dropped. Read responses may return out of order, across beats and across requests, and are reassembled in a slot buffer that supports multiple outstanding reads. Completed reads are returned to the source strictly in request order. The block sits between a cache/AFU-side bus and a narrower DRAM/host memory channel.

---
 rtl/vx_mem_adapter.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vx_mem_adapter.sv
// vx_mem_adapter: splits each wide source memory request into P narrower
// destination beats, where P = SRC_DATA_WIDTH / DST_DATA_WIDTH. Write beats
// whose byteen slice is all zero can be dropped. Read responses may arrive
// in any order. They are reassembled in RSP_SLOTS slots and are returned to
// the source in request order.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   mem_req_*_in  / mem_req_ready_in   source request (wide)
//   mem_req_*_out / mem_req_ready_out  destination request (narrow)
//   mem_rsp_*_in  / mem_rsp_ready_in   destination response (narrow)
//   mem_rsp_*_out / mem_rsp_ready_out  source response (wide)
// Request rw: 1 = write, 0 = read.
// Destination tag layout is {slot, beat}. Destination address is {addr, beat}.

module vx_mem_adapter #(
  parameter int SRC_DATA_WIDTH = 512,
  parameter int SRC_ADDR_WIDTH = 26,
  parameter int DST_DATA_WIDTH = 64,
  parameter int DST_ADDR_WIDTH = 29,
  parameter int SRC_TAG_WIDTH  = 8,
  parameter int DST_TAG_WIDTH  = 8,
  parameter int RSP_SLOTS      = 4,
  parameter int SKIP_EMPTY_WR  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_req_valid_in,
  input  logic                        mem_req_rw_in,
  input  logic [SRC_ADDR_WIDTH-1:0]   mem_req_addr_in,
  input  logic [SRC_DATA_WIDTH/8-1:0] mem_req_byteen_in,
  input  logic [SRC_DATA_WIDTH-1:0]   mem_req_data_in,
  input  logic [SRC_TAG_WIDTH-1:0]    mem_req_tag_in,
  output logic                        mem_req_ready_in,
  output logic                        mem_req_valid_out,
  output logic                        mem_req_rw_out,
  output logic [DST_ADDR_WIDTH-1:0]   mem_req_addr_out,
  output logic [DST_DATA_WIDTH/8-1:0] mem_req_byteen_out,
  output logic [DST_DATA_WIDTH-1:0]   mem_req_data_out,
  output logic [DST_TAG_WIDTH-1:0]    mem_req_tag_out,
  input  logic                        mem_req_ready_out,
  input  logic                        mem_rsp_valid_in,
  input  logic [DST_DATA_WIDTH-1:0]   mem_rsp_data_in,
  input  logic [DST_TAG_WIDTH-1:0]    mem_rsp_tag_in,
  output logic                        mem_rsp_ready_in,
  output logic                        mem_rsp_valid_out,
  output logic [SRC_DATA_WIDTH-1:0]   mem_rsp_data_out,
  output logic [SRC_TAG_WIDTH-1:0]    mem_rsp_tag_out,
  input  logic                        mem_rsp_ready_out
);

  localparam int P   = SRC_DATA_WIDTH / DST_DATA_WIDTH;
  localparam int D   = $clog2(P);
  localparam int DW  = (D > 0) ? D : 1;
  localparam int S   = $clog2(RSP_SLOTS);
  localparam int DBE = DST_DATA_WIDTH / 8;
  localparam int AW  = SRC_ADDR_WIDTH + D;
  localparam int TW  = S + D;
  localparam logic [S:0] OCC_FULL = (S+1)'(RSP_SLOTS);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                      state_r, next_state_s;
  logic [SRC_ADDR_WIDTH-1:0]   addr_r;
  logic                        rw_r;
  logic [SRC_DATA_WIDTH/8-1:0] byteen_r;
  logic [SRC_DATA_WIDTH-1:0]   data_r;
  logic [S-1:0]                slot_r;
  logic [DW-1:0]               beat_r;

  logic [S-1:0]                head_r, tail_r;
  logic [S:0]                  occ_r;
  logic [P-1:0]                slot_mask_r [RSP_SLOTS];
  logic [SRC_DATA_WIDTH-1:0]   slot_data_r [RSP_SLOTS];
  logic [SRC_TAG_WIDTH-1:0]    slot_tag_r  [RSP_SLOTS];

  logic [P-1:0]  nz_s;
  logic [DW-1:0] cur_beat_s;
  logic          has_beat_s, last_beat_s, more_s;
  logic          req_fire_in_s, req_fire_out_s, alloc_s, rsp_fire_s;
  logic [S-1:0]  rsp_slot_s;
  logic [DW-1:0] rsp_beat_s;
  logic [AW-1:0] full_addr_s;
  logic [TW-1:0] full_tag_s;

  assign req_fire_in_s  = mem_req_valid_in && mem_req_ready_in;
  assign req_fire_out_s = mem_req_valid_out && mem_req_ready_out;
  assign alloc_s        = req_fire_in_s && !mem_req_rw_in;
  assign rsp_fire_s     = mem_rsp_valid_out && mem_rsp_ready_out;

  // Slots are reserved at request time, so responses are never back-pressured.
  assign mem_rsp_ready_in = 1'b1;
  assign rsp_slot_s       = S'(mem_rsp_tag_in >> D);
  assign rsp_beat_s       = (D == 0) ? '0 : DW'(mem_rsp_tag_in);

  // Per-beat flag marking which latched byteen slices have at least one byte set.
  always_comb begin
    nz_s = '0;
    for (int i = 0; i < P; i++) begin
      nz_s[i] = |byteen_r[i*DBE +: DBE];
    end
  end

  // Select the beat to present now. Skipping writes jump ahead to the next
  // non-empty slice. The beat is last when no non-empty slice follows it.
  always_comb begin
    cur_beat_s  = beat_r;
    has_beat_s  = 1'b1;
    last_beat_s = (beat_r == DW'(P-1));
    more_s      = 1'b0;
    if (rw_r && (SKIP_EMPTY_WR != 0)) begin
      has_beat_s = 1'b0;
      for (int i = P-1; i >= 0; i--) begin
        if (nz_s[i] && (i >= int'(beat_r))) begin
          cur_beat_s = DW'(i);
          has_beat_s = 1'b1;
        end else begin
          has_beat_s = has_beat_s;
        end
      end
      for (int i = 0; i < P; i++) begin
        more_s = more_s | (nz_s[i] && (i > int'(cur_beat_s)));
      end
      last_beat_s = !more_s;
    end else begin
      more_s = 1'b0;
    end
  end

  // Destination request fields for the selected beat.
  assign full_addr_s        = (AW'(addr_r) << D) | AW'(cur_beat_s);
  assign full_tag_s         = (TW'(slot_r) << D) | TW'(cur_beat_s);
  assign mem_req_addr_out   = DST_ADDR_WIDTH'(full_addr_s);
  assign mem_req_tag_out    = DST_TAG_WIDTH'(full_tag_s);
  assign mem_req_rw_out     = rw_r;
  assign mem_req_data_out   = data_r[int'(cur_beat_s)*DST_DATA_WIDTH +: DST_DATA_WIDTH];
  assign mem_req_byteen_out = byteen_r[int'(cur_beat_s)*DBE +: DBE];

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sequencer next state and handshake outputs.
  always_comb begin
    next_state_s      = state_r;
    mem_req_ready_in  = 1'b0;
    mem_req_valid_out = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_req_rw_in) begin
          mem_req_ready_in = 1'b1;
        end else begin
          mem_req_ready_in = (occ_r < OCC_FULL);
        end
        if (mem_req_valid_in && mem_req_ready_in) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        mem_req_valid_out = has_beat_s;
        if (!has_beat_s) begin
          next_state_s = IDLE;
        end else if (mem_req_ready_out && last_beat_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = ISSUE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Latch the accepted request and advance the beat counter on each destination fire.
  always_ff @(posedge clk) begin
    if (req_fire_in_s) begin
      addr_r   <= mem_req_addr_in;
      rw_r     <= mem_req_rw_in;
      byteen_r <= mem_req_byteen_in;
      data_r   <= mem_req_data_in;
      slot_r   <= tail_r;
      beat_r   <= '0;
    end else if (req_fire_out_s) begin
      beat_r <= cur_beat_s + DW'(1);
    end
  end

  // Slot bookkeeping: pointers, occupancy and per-slot beat-valid masks.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= '0;
      for (int s = 0; s < RSP_SLOTS; s++) begin
        slot_mask_r[s] <= '0;
      end
    end else begin
      if (alloc_s) begin
        tail_r <= tail_r + S'(1);
      end
      if (rsp_fire_s) begin
        head_r <= head_r + S'(1);
      end
      case ({alloc_s, rsp_fire_s})
        2'b10:   occ_r <= occ_r + (S+1)'(1);
        2'b01:   occ_r <= occ_r - (S+1)'(1);
        default: occ_r <= occ_r;
      endcase
      if (mem_rsp_valid_in) begin
        slot_mask_r[rsp_slot_s][rsp_beat_s] <= 1'b1;
      end
      if (rsp_fire_s) begin
        slot_mask_r[head_r] <= '0;
      end
    end
  end

  // Slot payload storage: source tag at allocation, response beats as they arrive.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      slot_tag_r[tail_r] <= mem_req_tag_in;
    end
    if (mem_rsp_valid_in) begin
      slot_data_r[rsp_slot_s][int'(rsp_beat_s)*DST_DATA_WIDTH +: DST_DATA_WIDTH] <= mem_rsp_data_in;
    end
  end

  assign mem_rsp_valid_out = (occ_r != '0) && (&slot_mask_r[head_r]);
  assign mem_rsp_data_out  = slot_data_r[head_r];
  assign mem_rsp_tag_out   = slot_tag_r[head_r];

  vx_mem_adapter_chk #(.S(S)) u_chk (
    .clk      (clk),
    .reset    (reset),
    .rsp_fire (mem_rsp_valid_in),
    .rsp_slot (rsp_slot_s),
    .head     (head_r),
    .occ      (occ_r),
    .beat_set (slot_mask_r[rsp_slot_s][rsp_beat_s])
  );

endmodule

// vx_mem_adapter_chk: runtime checks on incoming destination responses.
// A response must target a slot that is currently allocated. A response must
// not hit a beat that has already been received.
module vx_mem_adapter_chk #(
  parameter int S = 2
) (
  input logic         clk,
  input logic         reset,
  input logic         rsp_fire,
  input logic [S-1:0] rsp_slot,
  input logic [S-1:0] head,
  input logic [S:0]   occ,
  input logic         beat_set
);

  logic [S-1:0] rel_s;
  assign rel_s = rsp_slot - head;

  a_rsp_slot_allocated: assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> ({1'b0, rel_s} < occ));

  a_rsp_beat_unique: assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> !beat_set);

endmodule
